sum_acc_n: RTL and testbench
============================

# sum_acc_n

Sequential accumulator that sits directly downstream of the n-bit ripple adder and consumes its `{over, sum}` result stream. It sums a programmed number of adder results into a widened register that cannot overflow, then presents the total with a valid/ready handshake. A three-state FSM (IDLE, ACC, DONE) controls the block. Input acceptance is gated by `ready_o` so upstream logic can stall the adder stage.

## Interface
- `n`, default 8: adder result width; `sum_i` width.
- `CNT_W`, default 4: width of the beat count `len_i`; at most 2^CNT_W−1 beats per run.
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: starts a run; sampled only in IDLE.
- `len_i` input CNT_W: number of beats to accumulate; latched on the accepted start.
- `sum_i` input n: adder sum.
- `over_i` input 1: adder carry-out; forms bit n of the beat value.
- `valid_i` input 1: `sum_i`/`over_i` are valid this cycle.
- `ready_o` output 1: block accepts a beat this cycle.
- `acc_o` output n+1+CNT_W: accumulated total.
- `cnt_o` output CNT_W: beats accepted so far in the current run.
- `valid_o` output 1: `acc_o` is the final total.
- `ready_i` input 1: consumer accepts the total.
- `busy_o` output 1: high in ACC and DONE.

## Operation
- The beat value is the zero-extension of `{over_i, sum_i}` to n+1+CNT_W bits.
- Accumulation is unsigned and modulo-free. Maximum total is (2^CNT_W−1)·(2^(n+1)−1) < 2^(n+1+CNT_W), so `acc_o` never wraps.
- All outputs decode from registered state only. There is no combinational path from any input to any output.

FSM behaviour:
- **IDLE:** `ready_o`=0, `valid_o`=0, `busy_o`=0.
  - On `start_i`=1, `len_i` is latched, and `acc_o` and `cnt_o` clear to 0.
  - If `len_i`≠0, go to ACC. If `len_i`=0, go to DONE with `acc_o`=0.
- **ACC:** `ready_o`=1, `busy_o`=1.
  - Each cycle with `valid_i`=1 is a beat: `acc_o` += beat value and `cnt_o` += 1.
  - If this beat makes `cnt_o`+1 equal the latched length, go to DONE on the same edge.
  - Cycles with `valid_i`=0 change nothing.
- **DONE:** `valid_o`=1, `ready_o`=0, `busy_o`=1.
  - `acc_o` and `cnt_o` are held.
  - When `ready_i`=1, go to IDLE.
- After a run, `acc_o` and `cnt_o` keep their final values in IDLE until the next accepted start.
- `start_i` is ignored in ACC and DONE. It is not queued.
- `valid_i` outside ACC is ignored. Those beats are dropped, not buffered.

## Timing
Reset:
- `rst_i`=1 at a rising edge sets state to IDLE.
- After that edge: `acc_o`=0, `cnt_o`=0, `valid_o`=0, `ready_o`=0, `busy_o`=0.
- `rst_i` has priority over every other input.
- Reset mid-run (ACC or DONE) discards the partial or final total.

Cycle behaviour:
- **Start:** a start accepted at edge k puts `ready_o`=1 from edge k. The first beat can be accepted at edge k+1.
- **Throughput:** one beat per cycle while `valid_i` is held high.
- **Latency:** the final beat accepted at edge k gives `valid_o`=1 and the final `acc_o` immediately after edge k. `ready_o` drops at the same edge.
- **Output handshake:** `valid_o` stays high, and `acc_o` stays stable, until an edge with `ready_i`=1.
  - `valid_o` is high for at least one cycle, even if `ready_i` is tied high.
  - IDLE is re-entered after that edge. A new start can be accepted at the following edge.
- **Zero length:** `len_i`=0 reaches DONE one edge after the start, with `acc_o`=0 and `cnt_o`=0.
- **Maximum length:** `len_i`=2^CNT_W−1 ends with `cnt_o` at all-ones. The count comparison happens before any wrap.

## Test plan
All scenarios use n=8 and CNT_W=4, so `acc_o` is 13 bits wide.
1. **Reset values:** hold `rst_i` for 2 cycles with random inputs → all outputs are 0.
   - Then assert reset mid-ACC after 2 beats → outputs return to 0, and a fresh run sums correctly.
2. **Basic run:** start with `len_i`=3, feed beats (0xFF, over=1), (0x01, 0), (0x10, 0) → `valid_o`=1 with `acc_o`=0x210 and `cnt_o`=3.
   - `valid_o` rises the cycle after the third beat.
3. **Gaps and backpressure:** `len_i`=2 with `valid_i` toggled on/off, then `ready_i` held low for 5 cycles.
   - Only the qualified beats are summed.
   - `valid_o` and `acc_o` stay constant for the 5 cycles.
   - IDLE is reached one edge after `ready_i` rises.
4. **Maximum sum:** `len_i`=15, 15 beats of 0xFF with over=1 → `acc_o`=0x1DF1 (7665) and `cnt_o`=0xF, with no wrap.
5. **Zero length:** start with `len_i`=0 → DONE the next cycle with `acc_o`=0; no beats are accepted.
6. **Ignored start and stray beats:**
   - Pulse `start_i` with `len_i`=7 during ACC of a `len_i`=2 run → the run still ends after 2 beats.
   - Drive `valid_i`=1 in IDLE and in DONE → `acc_o` is unaffected.

Source files
------------

// File: rtl/sum_acc_n.sv
// Accumulator downstream of the n-bit ripple adder. It sums a programmed number of
// {over, sum} beats into a register wide enough never to wrap, then hands off the total.
module sum_acc_n #(
  parameter int unsigned n     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     len_i,
  input  logic [n-1:0]         sum_i,
  input  logic                 over_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [n+CNT_W:0]     acc_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o
);

  localparam int unsigned AccW = n + 1 + CNT_W;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e            state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;

  logic [AccW-1:0]   beat;
  logic [CNT_W:0]    cnt_inc;

  assign beat    = {{CNT_W{1'b0}}, over_i, sum_i};
  // One extra bit so a full-length run is detected before the count wraps.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = len_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (len_i == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (valid_i) begin
          acc_d = acc_q + beat;
          cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_inc == {1'b0, len_q}) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Outputs decode from registered state only.
  assign ready_o = (state_q == StAcc);
  assign valid_o = (state_q == StDone);
  assign busy_o  = (state_q != StIdle);
  assign acc_o   = acc_q;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_sum_acc_n.sv
// Directed bench for sum_acc_n with n=8, CNT_W=4 (13-bit total).
module tb_sum_acc_n;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  len_i = '0;
  logic [7:0]  sum_i = '0;
  logic        over_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [12:0] acc_o;
  logic [3:0]  cnt_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  sum_acc_n #(.n(8), .CNT_W(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .len_i   (len_i),
    .sum_i   (sum_i),
    .over_i  (over_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .acc_o   (acc_o),
    .cnt_o   (cnt_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [3:0] len);
    start_i = 1'b1;
    len_i   = len;
    step();
    start_i = 1'b0;
  endtask

  task automatic do_beat(input logic [7:0] s, input logic o);
    valid_i = 1'b1;
    sum_i   = s;
    over_i  = o;
    step();
    valid_i = 1'b0;
  endtask

  task automatic release_total();
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] outs;
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_i = 1'($urandom);
      len_i   = 4'($urandom);
      sum_i   = 8'($urandom);
      over_i  = 1'($urandom);
      valid_i = 1'($urandom);
      ready_i = 1'($urandom);
      step();
    end
    outs = {acc_o, cnt_o, valid_o, ready_o, busy_o};
    tests++;
    if (outs !== 21'd0) begin
      fails++;
      $display("FAIL reset_values: got %h, want 0", outs);
    end
    start_i = 0; valid_i = 0; ready_i = 0;
    rst_i = 1'b0;
    step();
    // Reset mid-ACC after two beats
    do_start(4'd5);
    do_beat(8'h40, 1'b0);
    do_beat(8'h41, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    outs = {acc_o, cnt_o, valid_o, ready_o, busy_o};
    tests++;
    if (outs !== 21'd0) begin
      fails++;
      $display("FAIL reset_mid_acc: got %h, want 0", outs);
    end
    do_start(4'd2);
    do_beat(8'h03, 1'b0);
    do_beat(8'h04, 1'b0);
    tests++;
    if (acc_o !== 13'h007 || valid_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_fresh_run: acc=%h valid=%b, want 007 1", acc_o, valid_o);
    end
    release_total();
  endtask

  task automatic test_basic();
    do_start(4'd3);
    tests++;
    if ({ready_o, valid_o, busy_o, cnt_o, acc_o} !== {3'b101, 4'd0, 13'd0}) begin
      fails++;
      $display("FAIL basic_start: ready=%b valid=%b busy=%b cnt=%h acc=%h, want 1 0 1 0 0",
               ready_o, valid_o, busy_o, cnt_o, acc_o);
    end
    do_beat(8'hFF, 1'b1);
    do_beat(8'h01, 1'b0);
    tests++;
    if (valid_o !== 1'b0 || cnt_o !== 4'd2 || acc_o !== 13'h200) begin
      fails++;
      $display("FAIL basic_partial: valid=%b cnt=%h acc=%h, want 0 2 200", valid_o, cnt_o, acc_o);
    end
    do_beat(8'h10, 1'b0);
    tests++;
    if ({valid_o, ready_o, busy_o} !== 3'b101 || acc_o !== 13'h210 || cnt_o !== 4'd3) begin
      fails++;
      $display("FAIL basic_done: valid=%b ready=%b busy=%b acc=%h cnt=%h, want 1 0 1 210 3",
               valid_o, ready_o, busy_o, acc_o, cnt_o);
    end
    release_total();
    tests++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || acc_o !== 13'h210 || cnt_o !== 4'd3) begin
      fails++;
      $display("FAIL basic_idle_hold: valid=%b busy=%b acc=%h cnt=%h, want 0 0 210 3",
               valid_o, busy_o, acc_o, cnt_o);
    end
  endtask

  task automatic test_gaps();
    int bad;
    do_start(4'd2);
    valid_i = 1'b1; sum_i = 8'h22; over_i = 1'b0; step();
    valid_i = 1'b0; sum_i = 8'h55; over_i = 1'b1; step();
    valid_i = 1'b1; sum_i = 8'h33; over_i = 1'b1; step();
    valid_i = 1'b0;
    tests++;
    if (valid_o !== 1'b1 || acc_o !== 13'h155 || cnt_o !== 4'd2) begin
      fails++;
      $display("FAIL gaps_sum: valid=%b acc=%h cnt=%h, want 1 155 2", valid_o, acc_o, cnt_o);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid_o !== 1'b1 || acc_o !== 13'h155) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL backpressure_hold: %0d unstable cycles, want 0", bad);
    end
    release_total();
    tests++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release: busy=%b valid=%b, want 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_max();
    do_start(4'd15);
    for (int i = 0; i < 14; i++) do_beat(8'hFF, 1'b1);
    tests++;
    if (valid_o !== 1'b0 || cnt_o !== 4'd14) begin
      fails++;
      $display("FAIL max_before_last: valid=%b cnt=%h, want 0 e", valid_o, cnt_o);
    end
    do_beat(8'hFF, 1'b1);
    tests++;
    if (valid_o !== 1'b1 || acc_o !== 13'h1DF1 || cnt_o !== 4'hF) begin
      fails++;
      $display("FAIL max_sum: valid=%b acc=%h cnt=%h, want 1 1df1 f", valid_o, acc_o, cnt_o);
    end
    release_total();
  endtask

  task automatic test_zero_len();
    valid_i = 1'b1; sum_i = 8'h99; over_i = 1'b1;
    do_start(4'd0);
    tests++;
    if ({valid_o, ready_o, busy_o} !== 3'b101 || acc_o !== 13'd0 || cnt_o !== 4'd0) begin
      fails++;
      $display("FAIL zero_len_done: valid=%b ready=%b busy=%b acc=%h cnt=%h, want 1 0 1 0 0",
               valid_o, ready_o, busy_o, acc_o, cnt_o);
    end
    step();
    valid_i = 1'b0;
    tests++;
    if (valid_o !== 1'b1 || acc_o !== 13'd0 || cnt_o !== 4'd0) begin
      fails++;
      $display("FAIL zero_len_no_beats: valid=%b acc=%h cnt=%h, want 1 0 0", valid_o, acc_o, cnt_o);
    end
    release_total();
  endtask

  task automatic test_ignored();
    do_start(4'd2);
    do_beat(8'h10, 1'b0);
    start_i = 1'b1; len_i = 4'd7;
    do_beat(8'h20, 1'b0);
    start_i = 1'b0;
    tests++;
    if (valid_o !== 1'b1 || acc_o !== 13'h030 || cnt_o !== 4'd2) begin
      fails++;
      $display("FAIL ignored_start: valid=%b acc=%h cnt=%h, want 1 030 2", valid_o, acc_o, cnt_o);
    end
    valid_i = 1'b1; sum_i = 8'h77; over_i = 1'b1;
    step();
    step();
    tests++;
    if (acc_o !== 13'h030 || cnt_o !== 4'd2) begin
      fails++;
      $display("FAIL stray_beat_done: acc=%h cnt=%h, want 030 2", acc_o, cnt_o);
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    step();
    valid_i = 1'b0;
    tests++;
    if (acc_o !== 13'h030 || cnt_o !== 4'd2 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL stray_beat_idle: acc=%h cnt=%h busy=%b, want 030 2 0", acc_o, cnt_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    do_start(4'd1);
    do_beat(8'h05, 1'b0);
    tests++;
    if (valid_o !== 1'b1 || acc_o !== 13'h005) begin
      fails++;
      $display("FAIL b2b_valid_min: valid=%b acc=%h, want 1 005", valid_o, acc_o);
    end
    step();
    tests++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: valid=%b busy=%b, want 0 0", valid_o, busy_o);
    end
    do_start(4'd1);
    tests++;
    if (ready_o !== 1'b1 || acc_o !== 13'd0 || cnt_o !== 4'd0) begin
      fails++;
      $display("FAIL b2b_restart: ready=%b acc=%h cnt=%h, want 1 0 0", ready_o, acc_o, cnt_o);
    end
    do_beat(8'h0A, 1'b1);
    tests++;
    if (acc_o !== 13'h10A || valid_o !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: acc=%h valid=%b, want 10a 1", acc_o, valid_o);
    end
    step();
    ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_max();
    test_zero_len();
    test_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
